// File: rtl/freq_gate_ctrl.sv
// Gated frequency counter: counts sig_in rising edges over a fixed sysclk window
// and latches the 4-digit BCD result, overflow flag and range at the end of each window.
module freq_gate_ctrl #(
    parameter int GATE_LONG  = 100000000,
    parameter int GATE_SHORT = 10000000
) (
    input  logic        sysclk,
    input  logic        rst,
    input  logic        modecontrol,
    input  logic        sig_in,
    output logic [15:0] bcd_out,
    output logic        overflow,
    output logic        range_out,
    output logic        valid,
    output logic        gate_active
);

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_GATE  = 2'd1,
        ST_LATCH = 2'd2
    } state_t;

    localparam logic [31:0] LONG_LAST  = 32'(GATE_LONG - 1);
    localparam logic [31:0] SHORT_LAST = 32'(GATE_SHORT - 1);

    state_t      state_r;
    state_t      state_next_s;
    logic        sync1_r;
    logic        sync2_r;
    logic        prev_r;
    logic        edge_r;
    logic [31:0] timer_r;
    logic [15:0] cnt_r;
    logic        ovf_r;
    logic        range_r;
    logic [31:0] gate_last_s;
    logic        timer_done_s;

    // Cascaded BCD increment; a digit at 9 wraps and carries upward.
    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        carry;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (r[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = r[4*i +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end else begin
                carry = 1'b0;
            end
        end
        return r;
    endfunction

    assign gate_last_s  = range_r ? SHORT_LAST : LONG_LAST;
    assign timer_done_s = (timer_r == gate_last_s);
    assign gate_active  = (state_r == ST_GATE);

    // Two-flop synchronizer followed by a registered rising-edge strobe.
    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            prev_r  <= 1'b0;
            edge_r  <= 1'b0;
        end else begin
            sync1_r <= sig_in;
            sync2_r <= sync1_r;
            prev_r  <= sync2_r;
            edge_r  <= sync2_r & ~prev_r;
        end
    end

    // FSM state register.
    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            state_r <= ST_CLEAR;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic: one CLEAR cycle, the gate window, one LATCH cycle.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_CLEAR: state_next_s = ST_GATE;
            ST_GATE: begin
                if (timer_done_s) begin
                    state_next_s = ST_LATCH;
                end else begin
                    state_next_s = ST_GATE;
                end
            end
            ST_LATCH: state_next_s = ST_CLEAR;
            default:  state_next_s = ST_CLEAR;
        endcase
    end

    // Window datapath: timer, saturating BCD counter, sticky overflow and range capture.
    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            timer_r <= 32'd0;
            cnt_r   <= 16'h0000;
            ovf_r   <= 1'b0;
            range_r <= 1'b0;
        end else begin
            case (state_r)
                ST_CLEAR: begin
                    timer_r <= 32'd0;
                    cnt_r   <= 16'h0000;
                    ovf_r   <= 1'b0;
                    range_r <= modecontrol;
                end
                ST_GATE: begin
                    timer_r <= timer_r + 32'd1;
                    if (edge_r) begin
                        if (cnt_r == 16'h9999) begin
                            ovf_r <= 1'b1;
                        end else begin
                            cnt_r <= bcd_inc(cnt_r);
                        end
                    end
                end
                default: begin
                    timer_r <= timer_r;
                end
            endcase
        end
    end

    // Result registers change only when leaving LATCH; valid pulses with them.
    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            bcd_out   <= 16'h0000;
            overflow  <= 1'b0;
            range_out <= 1'b0;
            valid     <= 1'b0;
        end else if (state_r == ST_LATCH) begin
            bcd_out   <= cnt_r;
            overflow  <= ovf_r;
            range_out <= range_r;
            valid     <= 1'b1;
        end else begin
            valid     <= 1'b0;
        end
    end

endmodule
